// File: rtl/axi_rule_pkg.sv
// Shared types and helpers for the runtime-programmable AXI address rule decoder.
// Rules use a fixed 64-bit-address maximum layout; narrower instances use the low address bits.
package axi_rule_pkg;

    localparam int MISS_CNT_W = 16;
    localparam int MAX_ADDR_W = 64;
    localparam int SLAVE_W    = 16;
    localparam int MAX_RULES  = 64;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] base;
        logic [MAX_ADDR_W-1:0] mask;
        logic [SLAVE_W-1:0]    slave;
        logic                  enabled;
    } rule_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

    function automatic int idx_w(input int num_slave);
        return (num_slave > 1) ? $clog2(num_slave) : 1;
    endfunction

    function automatic int ridx_w(input int num_rules);
        return (num_rules > 1) ? $clog2(num_rules) : 1;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int find_first_one(input logic [MAX_RULES-1:0] vec);
        int pos;
        pos = 0;
        for (int i = MAX_RULES - 1; i >= 0; i--) begin
            if (vec[i]) pos = i;
        end
        return pos;
    endfunction

endpackage

// File: rtl/axi_rule_prio_match.sv
// Combinational rule match, lowest-index priority select and overlap detect.
// Zero latency; no handshake of its own.
module axi_rule_prio_match
    import axi_rule_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int NUM_SLAVE  = 4,
    parameter  int NUM_RULES  = 8,
    localparam int IDX_W      = idx_w(NUM_SLAVE)
) (
    input  rule_t [NUM_RULES-1:0] rules_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  hit_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  multi_o
);

    logic [NUM_RULES-1:0] match;
    int                   win;
    logic                 unused_rule_bits;

    assign unused_rule_bits = ^rules_i;

    always_comb begin
        match = '0;
        for (int j = 0; j < NUM_RULES; j++) begin
            // A rule pointing at a nonexistent slave can never win.
            match[j] = rules_i[j].enabled
                     && (rules_i[j].slave < SLAVE_W'(NUM_SLAVE))
                     && ((addr_i & rules_i[j].mask[ADDR_WIDTH-1:0])
                         == (rules_i[j].base[ADDR_WIDTH-1:0] & rules_i[j].mask[ADDR_WIDTH-1:0]));
        end
    end

    always_comb begin
        win   = find_first_one(MAX_RULES'(match));
        idx_o = '0;
        for (int j = 0; j < NUM_RULES; j++) begin
            if (match[j] && (j == win)) idx_o = rules_i[j].slave[IDX_W-1:0];
        end
    end

    assign hit_o   = |match;
    assign multi_o = |(match & (match - NUM_RULES'(1)));

endmodule

// File: rtl/axi_rule_decoder.sv
// Programmable base/mask address decoder with a single registered valid/ready result stage.
// One cycle req->rsp latency; req_ready_o = !rsp_valid_o | rsp_ready_i, result holds under stall.
module axi_rule_decoder
    import axi_rule_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int NUM_SLAVE   = 4,
    parameter  int NUM_RULES   = 8,
    parameter  int DEFAULT_EN  = 0,
    parameter  int DEFAULT_IDX = 0,
    localparam int IDX_W       = idx_w(NUM_SLAVE),
    localparam int RIDX_W      = ridx_w(NUM_RULES)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_we_i,
    input  logic [RIDX_W-1:0]     cfg_idx_i,
    input  rule_t                 cfg_rule_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [IDX_W-1:0]      rsp_idx_o,
    output logic                  rsp_ok_o,
    output logic                  rsp_multi_o,
    output logic [MISS_CNT_W-1:0] miss_cnt_o,
    input  logic                  miss_clr_i
);

    rule_t [NUM_RULES-1:0] rules_q;
    rsp_state_e            state_q, state_d;
    logic [IDX_W-1:0]      rsp_idx_q, rsp_idx_d;
    logic                  rsp_ok_q, rsp_ok_d;
    logic                  rsp_multi_q;
    logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic                  req_fire;
    logic                  hit;
    logic                  multi;
    logic [IDX_W-1:0]      match_idx;

    axi_rule_prio_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVE  (NUM_SLAVE),
        .NUM_RULES  (NUM_RULES)
    ) u_match (
        .rules_i (rules_q),
        .addr_i  (req_addr_i),
        .hit_o   (hit),
        .idx_o   (match_idx),
        .multi_o (multi)
    );

    assign req_ready_o = (state_q == ST_EMPTY) | rsp_ready_i;
    assign req_fire    = req_valid_i & req_ready_o;

    // Lookup in the same cycle as a write sees the old table, since both use rules_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rules_q <= '0;
        end else if (cfg_we_i) begin
            for (int j = 0; j < NUM_RULES; j++) begin
                if (cfg_idx_i == RIDX_W'(j)) rules_q[j] <= cfg_rule_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (req_fire) state_d = ST_FULL;
            ST_FULL:  if (rsp_ready_i && !req_fire) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        rsp_idx_d = match_idx;
        rsp_ok_d  = 1'b1;
        if (!hit) begin
            if (DEFAULT_EN != 0) begin
                rsp_idx_d = IDX_W'(DEFAULT_IDX);
            end else begin
                rsp_idx_d = '0;
                rsp_ok_d  = 1'b0;
            end
        end
    end

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (miss_clr_i) begin
            miss_cnt_d = '0;
        end else if (req_fire && !hit && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + MISS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            rsp_idx_q   <= '0;
            rsp_ok_q    <= 1'b0;
            rsp_multi_q <= 1'b0;
            miss_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            miss_cnt_q <= miss_cnt_d;
            if (req_fire) begin
                rsp_idx_q   <= rsp_idx_d;
                rsp_ok_q    <= rsp_ok_d;
                rsp_multi_q <= multi;
            end
        end
    end

    assign rsp_valid_o = (state_q == ST_FULL);
    assign rsp_idx_o   = rsp_idx_q;
    assign rsp_ok_o    = rsp_ok_q;
    assign rsp_multi_o = rsp_multi_q;
    assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: doc/axi_rule_decoder.md
# axi_rule_decoder

Runtime-programmable, pipelined address decoder for the AXI crossbar request path. It resolves a request address against a writable table of base/mask rules and returns the target slave index. Unlike the fixed combinational resolver, it has a table write port, lowest-index priority on overlapping rules, a default-slave/decode-error mode, a registered valid/ready result stage and a saturating miss counter. It sits between each crossbar master port and its AW/AR demux.

## Interface
- ADDR_WIDTH, 32: address width.
- NUM_SLAVE, 4: slave count, ≥1; IDX_W = max(1, $clog2(NUM_SLAVE)).
- NUM_RULES, 8: rule-table depth, ≥1; RIDX_W = max(1, $clog2(NUM_RULES)).
- DEFAULT_EN, 0: 1 = a miss routes to DEFAULT_IDX; 0 = a miss is a decode error.
- DEFAULT_IDX, 0: default slave index, < NUM_SLAVE.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_we_i  in  1  rule write strobe.
- cfg_idx_i  in  RIDX_W  rule slot to write.
- cfg_rule_i  in  rule_t  {base, mask, slave, enabled}.
- req_valid_i  in  1  lookup request valid.
- req_ready_o  out  1  lookup accepted when valid & ready.
- req_addr_i  in  ADDR_WIDTH  address to resolve.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result consumed.
- rsp_idx_o  out  IDX_W  resolved slave index.
- rsp_ok_o  out  1  1 = hit or default route; 0 = decode error.
- rsp_multi_o  out  1  more than one enabled rule matched.
- miss_cnt_o  out  16  saturating count of accepted lookups with no rule hit.
- miss_clr_i  in  1  synchronous clear of miss_cnt_o.

## Operation
- Rule j matches when enabled and (addr & mask) == (base & mask). A rule with mask = 0 matches every address.
- The lowest-index matching rule wins and gives rsp_idx = rule.slave. Overlapping rules are legal; rsp_multi_o flags the overlap and nothing asserts on it.
- Miss: with DEFAULT_EN=1, rsp_idx = DEFAULT_IDX and rsp_ok = 1. With DEFAULT_EN=0, rsp_idx = 0 and rsp_ok = 0. Both cases increment miss_cnt.
- A rule with slave ≥ NUM_SLAVE is treated as non-matching.
- Table writes: on cfg_we_i, slot cfg_idx_i is written at the clock edge. cfg_idx_i ≥ NUM_RULES is ignored.
- Simultaneous write and lookup: the lookup resolves against the pre-write table. The new rule applies from the next accepted request.
- Output stage is a single register: req_ready_o = !rsp_valid_o | rsp_ready_i.
- Result state machine, two states:
  - EMPTY → FULL on req fire.
  - FULL stays FULL on a new req fire while rsp_ready_i=1; the register reloads.
  - FULL → EMPTY when rsp_ready_i=1 and there is no new req fire.
- While rsp_valid_o=1 and rsp_ready_i=0, all rsp_* outputs hold stable.
- miss_cnt saturates at 0xFFFF.
- miss_clr_i has priority over an increment in the same cycle; the result is 0.

## Timing
- Latency is one cycle from req fire to rsp_valid_o. Throughput is one lookup per cycle while rsp_ready_i=1.
- No combinational path from req_addr_i or the table to any rsp_* output.
- There is a combinational path rsp_ready_i → req_ready_o.
- Reset values: all rules disabled (base, mask and slave = 0); rsp_valid_o=0, rsp_idx_o=0, rsp_ok_o=0, rsp_multi_o=0, miss_cnt_o=0. req_ready_o=1 after reset.
- Reset mid-operation: the pending result is dropped and the table is cleared. Software reprograms the table.

## Structure
- Package axi_rule_pkg holds:
  - rule_t (parametrised via typedef in the instantiating scope, or a fixed 64-bit-address maximum struct);
  - the IDX_W/RIDX_W helper functions;
  - the miss-counter width constant MISS_CNT_W=16.
- Sub-module axi_rule_prio_match is the combinational match vector, lowest-index priority encode and multi-hit detect. It reuses find_first_one.
- The top level holds the rule registers, output register, handshake and counter.

## Test plan
- Reset, write rule0 {base 0x1000_0000, mask 0xF000_0000, slave 2, en}, request 0x1234_5678 → next cycle rsp_valid=1, idx=2, ok=1, multi=0.
- Rule1 {0x0000_0000, mask 0, slave 3, en} overlapping rule0, request 0x1000_0004 → idx=2, multi=1. Request 0x2000_0000 → idx=3, multi=0.
- DEFAULT_EN=0, empty table, request 0x40 → ok=0, idx=0, miss_cnt=1. With DEFAULT_EN=1, DEFAULT_IDX=1 → ok=1, idx=1, miss_cnt=1.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 → req_ready=0 and rsp outputs stable. Release → back-to-back results, one per cycle, in order.
- Same-cycle write of rule0 (slave 2→1) and lookup of 0x1000_0000 → result idx=2; next lookup → idx=1.
- Force miss_cnt to 0xFFFF via 65535 misses → a further miss keeps 0xFFFF. Miss plus miss_clr in the same cycle → 0. Async reset with rsp_valid=1 → rsp_valid=0 immediately.
